lohi_unit: RTL and testbench

Multi-cycle multiply/divide engine owning the LO/HI register pair. Accepts MULT/MULTU/DIV/DIVU requests from the execute stage and MTLO/MTHI writes from the memory stage. Presents {HI,LO} plus a ready flag to the memory stage, which stalls MFLO/MFHI/MTLO/MTHI until ready. Raises busy so the execute stage holds a new mul/div request until the unit is idle.

---
 rtl/lohi_unit_pkg.sv | 39 +++
 rtl/lohi_unit_divider.sv | 96 +++++++++
 rtl/lohi_unit.sv | 152 +++++++++++++++
 tb/tb_lohi_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lohi_unit_pkg.sv
// Shared definitions for the LO/HI multiply/divide unit: request codes, write codes,
// FSM state encoding and a leading-zero helper used when LOHI_DIV_EARLY_EN is defined.
package lohi_unit_pkg;

  localparam int MD_OPT_WIDTH = 3;
  localparam logic [MD_OPT_WIDTH-1:0] MD_OPT_NONE  = 3'd0;
  localparam logic [MD_OPT_WIDTH-1:0] MD_OPT_MULT  = 3'd1;
  localparam logic [MD_OPT_WIDTH-1:0] MD_OPT_MULTU = 3'd2;
  localparam logic [MD_OPT_WIDTH-1:0] MD_OPT_DIV   = 3'd3;
  localparam logic [MD_OPT_WIDTH-1:0] MD_OPT_DIVU  = 3'd4;

  localparam int LOHI_WRITE_OPT_WIDTH = 2;
  localparam logic [LOHI_WRITE_OPT_WIDTH-1:0] LOHI_WRITE_NONE = 2'd0;
  localparam logic [LOHI_WRITE_OPT_WIDTH-1:0] LOHI_WRITE_LO   = 2'd1;
  localparam logic [LOHI_WRITE_OPT_WIDTH-1:0] LOHI_WRITE_HI   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } lohi_state_e;

  // Returns 32 for a zero input.
  function automatic logic [5:0] clz32(input logic [31:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'd32;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 6'(31 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/lohi_unit_divider.sv
// Iterative restoring magnitude divider, one quotient bit per cycle, MSB first.
// With LOHI_DIV_EARLY_EN defined, leading zeros of the dividend are skipped at start.
module lohi_divider
  import lohi_unit_pkg::*;
#(
  parameter int DIV_BITS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        last,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  localparam logic [5:0] CNT_FULL = 6'(DIV_BITS - 1);

  logic        active_q, active_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dsr_q, dsr_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [5:0]  cnt_init;
  logic [31:0] dvd_init;
  logic [32:0] trial;
  logic [32:0] diff;
  logic        fits;

`ifdef LOHI_DIV_EARLY_EN
  logic [5:0] lz;
  // A zero dividend still runs one iteration so the minimum latency stays at two cycles.
  always_comb begin
    lz = clz32(dividend);
    if (lz > 6'd31) lz = 6'd31;
    cnt_init = CNT_FULL - lz;
    dvd_init = dividend << lz;
  end
`else
  assign cnt_init = CNT_FULL;
  assign dvd_init = dividend;
`endif

  assign trial     = {rem_q, dvd_q[31]};
  assign diff      = trial - {1'b0, dsr_q};
  assign fits      = (trial >= {1'b0, dsr_q});
  assign last      = active_q && (cnt_q == '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    dvd_d    = dvd_q;
    dsr_d    = dsr_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    if (abort) begin
      active_d = 1'b0;
    end else if (start) begin
      active_d = 1'b1;
      cnt_d    = cnt_init;
      dvd_d    = dvd_init;
      dsr_d    = divisor;
      quo_d    = '0;
      rem_d    = '0;
    end else if (active_q) begin
      dvd_d = {dvd_q[30:0], 1'b0};
      quo_d = {quo_q[30:0], fits};
      rem_d = fits ? diff[31:0] : trial[31:0];
      if (cnt_q == '0) active_d = 1'b0;
      else             cnt_d    = cnt_q - 6'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    dvd_q <= dvd_d;
    dsr_q <= dsr_d;
    quo_q <= quo_d;
    rem_q <= rem_d;
  end

endmodule

// File: rtl/lohi_unit.sv
// LO/HI register pair with a pipelined multiplier and an iterative divider.
// Optional macro LOHI_DIV_EARLY_EN shortens divides by skipping dividend leading zeros.
module lohi_unit
  import lohi_unit_pkg::*;
#(
  parameter int MUL_LATENCY = 2,
  parameter int DIV_BITS    = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [MD_OPT_WIDTH-1:0]         md_opt,
  input  logic [31:0]                     md_a,
  input  logic [31:0]                     md_b,
  output logic                            busy,
  input  logic [LOHI_WRITE_OPT_WIDTH-1:0] lohi_write_opt,
  input  logic [31:0]                     lohi_write_data,
  output logic [63:0]                     lohi_value,
  output logic                            lohi_ready
);

  localparam int         PIPE_N       = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;
  localparam int         PIPE_LAST    = PIPE_N - 1;
  localparam logic [2:0] MUL_CNT_INIT = 3'(MUL_LATENCY - 1);

  lohi_state_e        state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        hi_q, hi_d;

  logic               idle, wr_lo, wr_hi, wr_en;
  logic               req_mul, req_div, div_signed;
  logic               accept_mul, accept_div, div_abort;
  logic signed [32:0] mul_a_q, mul_b_q;
  logic signed [65:0] prod;
  logic [63:0]        prod_pipe_q [PIPE_N];
  logic [63:0]        mul_res;
  logic               q_neg_q, r_neg_q, dz_q;
  logic [31:0]        a_mag, b_mag;
  logic               div_last;
  logic [31:0]        div_quo, div_rem, q_fix, r_fix;

  assign idle       = (state_q == ST_IDLE);
  assign busy       = !idle;
  assign lohi_ready = idle;
  assign lohi_value = {hi_q, lo_q};

  assign wr_lo      = (lohi_write_opt == LOHI_WRITE_LO);
  assign wr_hi      = (lohi_write_opt == LOHI_WRITE_HI);
  assign wr_en      = wr_lo || wr_hi;
  assign req_mul    = (md_opt == MD_OPT_MULT) || (md_opt == MD_OPT_MULTU);
  assign req_div    = (md_opt == MD_OPT_DIV) || (md_opt == MD_OPT_DIVU);
  assign div_signed = (md_opt == MD_OPT_DIV);
  // The memory-stage write is older than the execute-stage request, so it wins.
  assign accept_mul = idle && req_mul && !wr_en;
  assign accept_div = idle && req_div && !wr_en;
  assign div_abort  = wr_en && busy;

  assign a_mag = (div_signed && md_a[31]) ? -md_a : md_a;
  assign b_mag = (div_signed && md_b[31]) ? -md_b : md_b;

  // 33-bit operands carry the signed/unsigned choice in the extension bit.
  assign prod    = mul_a_q * mul_b_q;
  assign mul_res = (MUL_LATENCY == 1) ? prod[63:0] : prod_pipe_q[PIPE_LAST];

  assign q_fix = dz_q ? 32'hFFFF_FFFF : (q_neg_q ? -div_quo : div_quo);
  assign r_fix = r_neg_q ? -div_rem : div_rem;

  lohi_divider #(
    .DIV_BITS (DIV_BITS)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept_div),
    .abort     (div_abort),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .last      (div_last),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept_mul) begin
          state_d = ST_MUL;
          cnt_d   = MUL_CNT_INIT;
        end else if (accept_div) begin
          state_d = ST_DIV;
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          lo_d    = mul_res[31:0];
          hi_d    = mul_res[63:32];
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DIV: begin
        if (div_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        lo_d    = q_fix;
        hi_d    = r_fix;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // An MTLO/MTHI aborts any operation and beats a same-cycle completion.
    if (wr_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      lo_d    = wr_lo ? lohi_write_data : lo_q;
      hi_d    = wr_hi ? lohi_write_data : hi_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept_mul) begin
      mul_a_q <= {(md_opt == MD_OPT_MULT) && md_a[31], md_a};
      mul_b_q <= {(md_opt == MD_OPT_MULT) && md_b[31], md_b};
    end
    if (accept_div) begin
      q_neg_q <= div_signed && (md_a[31] ^ md_b[31]);
      r_neg_q <= div_signed && md_a[31];
      dz_q    <= (md_b == '0);
    end
    prod_pipe_q[0] <= prod[63:0];
    for (int i = 1; i < PIPE_N; i++) prod_pipe_q[i] <= prod_pipe_q[i-1];
  end

endmodule

// File: tb/tb_lohi_unit.sv
// Directed scoreboard bench for lohi_unit: mul/div results and latencies, MTLO/MTHI,
// aborts, ignored requests and asynchronous reset.
module tb_lohi_unit;
  import lohi_unit_pkg::*;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  md_opt;
  logic [31:0] md_a, md_b;
  logic        busy;
  logic [1:0]  lohi_write_opt;
  logic [31:0] lohi_write_data;
  logic [63:0] lohi_value;
  logic        lohi_ready;

  typedef struct {
    string       tag;
    logic [63:0] val;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_lo, exp_hi;

  lohi_unit #(.MUL_LATENCY(MUL_LAT), .DIV_BITS(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .md_opt          (md_opt),
    .md_a            (md_a),
    .md_b            (md_b),
    .busy            (busy),
    .lohi_write_opt  (lohi_write_opt),
    .lohi_write_data (lohi_write_data),
    .lohi_value      (lohi_value),
    .lohi_ready      (lohi_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model_val(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    logic [63:0] p;
    sa  = $signed(a);
    sbv = $signed(b);
    case (op)
      MD_OPT_MULT:  begin p = sa * sbv; return p; end
      MD_OPT_MULTU: return {32'b0, a} * {32'b0, b};
      MD_OPT_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      MD_OPT_DIVU: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] a);
    logic [31:0] mag;
    int lz;
    if (op == MD_OPT_MULT || op == MD_OPT_MULTU) return MUL_LAT;
    mag = (op == MD_OPT_DIV && a[31]) ? -a : a;
    lz = 32;
    for (int i = 31; i >= 0; i--) if (mag[i]) begin lz = 31 - i; break; end
`ifdef LOHI_DIV_EARLY_EN
    if (lz > 31) lz = 31;
    return (32 - lz) + 1;
`else
    return (lz >= 0) ? 33 : 33;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a request for one cycle; returns at the negedge after the accepting posedge.
  task automatic drive_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    md_opt = op; md_a = a; md_b = b;
    @(negedge clk);
    md_opt = MD_OPT_NONE;
  endtask

  task automatic issue(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.tag = tag;
    e.val = model_val(op, a, b);
    e.lat = model_lat(op, a);
    sb_q.push_back(e);
    drive_md(op, a, b);
  endtask

  // n0 = cycles already elapsed since the accepting posedge.
  task automatic collect(input int n0);
    exp_t e;
    int   n;
    n = n0;
    while (!lohi_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    e = sb_q.pop_front();
    chk({e.tag, " latency"}, 64'(n), 64'(e.lat));
    chk({e.tag, " value"}, lohi_value, e.val);
    exp_lo = e.val[31:0];
    exp_hi = e.val[63:32];
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    md_opt = MD_OPT_NONE; md_a = '0; md_b = '0;
    lohi_write_opt = LOHI_WRITE_NONE; lohi_write_data = '0;
    exp_lo = '0; exp_hi = '0;
    #12;
    chk("reset value", lohi_value, 64'd0);
    chk("reset ready", 64'(lohi_ready), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    issue("mult -2*3", MD_OPT_MULT, 32'hFFFF_FFFE, 32'd3);
    collect(0);
    issue("multu max*max", MD_OPT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    collect(0);
    issue("div -7/2", MD_OPT_DIV, 32'hFFFF_FFF9, 32'd2);
    collect(0);
    issue("divu 7/0", MD_OPT_DIVU, 32'd7, 32'd0);
    collect(0);
    issue("div -7/0", MD_OPT_DIV, 32'hFFFF_FFF9, 32'd0);
    collect(0);
    issue("div overflow", MD_OPT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    collect(0);
    issue("div 100/-7", MD_OPT_DIV, 32'd100, 32'hFFFF_FFF9);
    collect(0);
    issue("divu 5/1", MD_OPT_DIVU, 32'd5, 32'd1);
    collect(0);
    issue("div 0/9", MD_OPT_DIV, 32'd0, 32'd9);
    collect(0);

    // MTLO then MTHI while idle
    @(negedge clk);
    lohi_write_opt = LOHI_WRITE_LO; lohi_write_data = 32'hCAFE_0001;
    @(negedge clk);
    chk("mtlo keeps hi", lohi_value, {exp_hi, 32'hCAFE_0001});
    lohi_write_opt = LOHI_WRITE_HI; lohi_write_data = 32'h0BAD_0002;
    @(negedge clk);
    lohi_write_opt = LOHI_WRITE_NONE;
    chk("mthi keeps lo", lohi_value, {32'h0BAD_0002, 32'hCAFE_0001});
    exp_lo = 32'hCAFE_0001; exp_hi = 32'h0BAD_0002;

    // MTHI during a divide aborts it
    drive_md(MD_OPT_DIVU, 32'd100, 32'd7);
    chk("divu busy", 64'(busy), 64'd1);
    repeat (3) @(negedge clk);
    lohi_write_opt = LOHI_WRITE_HI; lohi_write_data = 32'h0000_1234;
    @(negedge clk);
    lohi_write_opt = LOHI_WRITE_NONE;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort value", lohi_value, {32'h0000_1234, exp_lo});
    exp_hi = 32'h0000_1234;
    repeat (40) @(negedge clk);
    chk("abort no overwrite", lohi_value, {exp_hi, exp_lo});

    // MULT while a divide is busy is ignored
    issue("div 1000/-3 with mult", MD_OPT_DIV, 32'd1000, 32'hFFFF_FFFD);
    md_opt = MD_OPT_MULT; md_a = 32'd9; md_b = 32'd9;
    @(negedge clk);
    @(negedge clk);
    md_opt = MD_OPT_NONE;
    collect(2);
    repeat (4) @(negedge clk);
    chk("ignored mult no effect", lohi_value, {exp_hi, exp_lo});

    // Same-edge request and MTLO while idle: the write wins
    @(negedge clk);
    md_opt = MD_OPT_MULT; md_a = 32'd3; md_b = 32'd5;
    lohi_write_opt = LOHI_WRITE_LO; lohi_write_data = 32'h0000_0055;
    @(negedge clk);
    md_opt = MD_OPT_NONE; lohi_write_opt = LOHI_WRITE_NONE;
    chk("same-edge busy", 64'(busy), 64'd0);
    chk("same-edge value", lohi_value, {exp_hi, 32'h0000_0055});
    exp_lo = 32'h0000_0055;
    repeat (4) @(negedge clk);
    chk("same-edge no mult", lohi_value, {exp_hi, exp_lo});

    // Asynchronous reset mid-divide
    drive_md(MD_OPT_DIV, 32'd12345, 32'd7);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async rst value", lohi_value, 64'd0);
    chk("async rst ready", 64'(lohi_ready), 64'd1);
    #1 rst = 1'b1;
    exp_lo = '0; exp_hi = '0;
    repeat (40) @(negedge clk);
    chk("after rst no result", lohi_value, 64'd0);

    for (int i = 0; i < 8; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'(1 + (i % 4));
      a  = $urandom;
      b  = $urandom;
      if (i == 5) b = 32'd3;
      if (i == 6) a = a >> 20;
      issue($sformatf("random %0d op %0d", i, op), op, a, b);
      collect(0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
